mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised memory-access stage for the MIPS32 five-stage pipeline, replacing the pass-through MEM stage between EX/MEM and MEM/WB. Forwards ALU, HI/LO and write-back fields unchanged for non-memory instructions. Executes LB/LBU/LH/LHU/LW/SB/SH/SW and, optionally, LL/SC against a req/ack data-memory bus. Stalls the pipeline until the bus completes, the access faults, or it times out.

## Interface
Parameters:
- ADDR_W, 32: data-memory address width; `mem_addr_i` and `dm_addr_o` use this width.
- TIMEOUT, 255: maximum cycles spent in BUSY before abort; 0 disables the timeout.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock; all state changes on the rising edge.
  - rst  in  1  synchronous reset, active-high.
- Write-back and HI/LO fields:
  - wd_i  in  5  destination register address.
  - wreg_i  in  1  register write enable.
  - wdata_i  in  32  ALU result.
  - hi_i / lo_i  in  32 each  HI/LO write data.
  - whilo_i  in  1  HI/LO write enable.
- Memory-operation fields:
  - mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11–15 treated as 0.
  - mem_addr_i  in  ADDR_W  effective address.
  - mem_sdata_i  in  32  store data (rt).
- Outputs:
  - wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  as the corresponding inputs  fields to MEM/WB.
  - stallreq_o  out  1  pipeline stall request.
  - excp_o  out  2  bit0 AdEL (load misaligned), bit1 AdES (store misaligned).
  - bus_err_o  out  1  timeout abort, one-cycle pulse.
- Data-memory bus:
  - dm_req_o, dm_we_o  out  1 each.
  - dm_addr_o  out  ADDR_W  word-aligned address, low two bits zero.
  - dm_sel_o  out  4  byte lane selects.
  - dm_wdata_o  out  32.
  - dm_rdata_i  in  32.
  - dm_ack_i  in  1.

## Operation
- Non-memory op (mem_op_i = 0): all outputs combinationally equal their inputs; no stall.
- Alignment rules:
  - Halfword ops need addr[0] = 0; word ops need addr[1:0] = 0.
  - On a misaligned op: no bus access, `excp_o` bit set combinationally, `wreg_o` = 0, no stall.
- Byte lanes are big-endian:
  - Byte: addr[1:0] = 0 → sel 1000, 1 → 0100, 2 → 0010, 3 → 0001.
  - Halfword: addr[1] = 0 → 1100, 1 → 0011. Word: 1111.
- Store data is replicated across lanes: SB {4{b}}, SH {2{h}}.
- Load data is taken from the selected lanes: LB/LH sign-extend, LBU/LHU zero-extend.
- FSM states IDLE, BUSY, DONE; reset → IDLE.
  - IDLE + valid aligned memory op:
    - `stallreq_o` = 1.
    - Next edge: load `dm_*` registers and set `dm_req_o` = 1.
    - Clear the timeout counter; go to BUSY.
  - BUSY:
    - `stallreq_o` = 1; `dm_req_o` and all `dm_*` outputs held stable.
    - `dm_ack_i` = 1: capture `dm_rdata_i` into the load register, drop `dm_req_o` next edge, go to DONE.
    - Counter reaches TIMEOUT (TIMEOUT ≠ 0) without ack: drop `dm_req_o`, pulse `bus_err_o`, go to DONE with write-back suppressed.
  - DONE:
    - `stallreq_o` = 0.
    - Load: `wdata_o` = extended load data.
    - Store: `wreg_o` = `wreg_i`, except that SC writes its success value.
    - Next edge → IDLE.
- EX/MEM inputs are held stable by the upstream stall for the whole transaction.
- Ack and timeout in the same cycle: ack wins.
- `rst` mid-transaction: next edge → IDLE, `dm_req_o` = 0; any late ack in IDLE is ignored.

## Timing
- Reset values (registered): `dm_req_o` 0, `dm_we_o` 0, `dm_addr_o` 0, `dm_sel_o` 0, `dm_wdata_o` 0, `bus_err_o` 0, state IDLE, link bit 0.
- Combinational outputs during `rst`:
  - `wd_o` 0, `wreg_o` 0, `wdata_o` 0, `hi_o` 0, `lo_o` 0, `whilo_o` 0, `stallreq_o` 0, `excp_o` 0.
- Latency, op presented at cycle 0:
  - `dm_req_o` high from cycle 1.
  - Ack at cycle k ≥ 1 → DONE at k+1, stall high on cycles 0..k.
  - Minimum cost is 2 stall cycles.
- Timeout: `bus_err_o` high in the DONE cycle, TIMEOUT+1 cycles after `dm_req_o` rises.

## Configuration
- `MEM_LSU_LLSC_EN` defined:
  - Adds input `llbit_clr_i` (1 bit, e.g. ERET) and a link-bit register.
  - LL acts as LW and sets the link bit in DONE.
  - SC with link bit = 1: performs SW, writes 1 to rt, clears the link bit.
  - SC with link bit = 0: no bus access, no stall, writes 0 to rt.
  - `llbit_clr_i` clears the link bit on the next edge; a same-cycle LL set wins over the clear.
- `MEM_LSU_LLSC_EN` undefined:
  - No link bit and no `llbit_clr_i` port.
  - LL behaves as LW.
  - SC performs SW unconditionally and writes 1.

## Test plan
- mem_op 0, wdata_i 0x1234_5678, wreg_i 1 → same-cycle pass-through, `stallreq_o` 0.
- LB at addr 0x103, memory word 0x1122_33F4, ack in cycle 1 → `dm_sel_o` 0001, `wdata_o` 0xFFFF_FFF4 in DONE, stall on cycles 0–1.
- SH at addr 0x102, rt 0x0000_ABCD → `dm_sel_o` 0011, `dm_wdata_o` 0xABCD_ABCD, `dm_we_o` 1; LW at 0x102 → `excp_o` 01, no `dm_req_o`.
- TIMEOUT 4, no ack → `bus_err_o` pulse 5 cycles after req rise, `wreg_o` 0, `dm_req_o` low after the abort.
- `rst` asserted during BUSY, ack arriving afterward → IDLE and `dm_req_o` 0 after one edge, ack ignored.
- With `MEM_LSU_LLSC_EN`:
  - LL then SC → SC stores and writes 1.
  - LL, then `llbit_clr_i`, then SC → no bus access, writes 0.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Data-memory req/ack bus between mem_lsu (master) and the data memory (slave).
// Signal names carry the direction as seen from the LSU.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req_o;
  logic              dm_we_o;
  logic [ADDR_W-1:0] dm_addr_o;
  logic [3:0]        dm_sel_o;
  logic [31:0]       dm_wdata_o;
  logic [31:0]       dm_rdata_i;
  logic              dm_ack_i;

  modport master (
    output dm_req_o, dm_we_o, dm_addr_o, dm_sel_o, dm_wdata_o,
    input  dm_rdata_i, dm_ack_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_addr_o, dm_sel_o, dm_wdata_o,
    output dm_rdata_i, dm_ack_i
  );
endinterface

// File: rtl/mem_lsu.sv
// MIPS32 MEM stage: byte/half/word loads and stores over a req/ack bus with stall and timeout.
// Optional LL/SC link bit enabled by defining MEM_LSU_LLSC_EN.
//
// state | meaning
// IDLE  | pass-through; valid aligned memory op requests stall and launches bus access
// BUSY  | dm_req_o held high until ack or timeout
// DONE  | result presented to MEM/WB, stall released
module mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       hi_i,
  input  logic [31:0]       lo_i,
  input  logic              whilo_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              whilo_o,
  output logic              stallreq_o,
  output logic [1:0]        excp_o,
  output logic              bus_err_o,
`ifdef MEM_LSU_LLSC_EN
  input  logic              llbit_clr_i,
`endif
  mem_lsu_if.master         dm
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               req_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [3:0]         sel_q;
  logic [31:0]        wdata_q;
  logic               bus_err_q;
  logic [31:0]        ldata_q;
  logic [CNT_W-1:0]   cnt_q;

  logic        op_ld, op_st, op_sz_b, op_sz_h, op_sx, op_sc;
  logic        misal, sc_fail, go;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  always_comb begin
    op_ld   = 1'b0;
    op_st   = 1'b0;
    op_sz_b = 1'b0;
    op_sz_h = 1'b0;
    op_sx   = 1'b0;
    op_sc   = 1'b0;
    case (mem_op_i)
      OP_LB:  begin op_ld = 1'b1; op_sz_b = 1'b1; op_sx = 1'b1; end
      OP_LBU: begin op_ld = 1'b1; op_sz_b = 1'b1; end
      OP_LH:  begin op_ld = 1'b1; op_sz_h = 1'b1; op_sx = 1'b1; end
      OP_LHU: begin op_ld = 1'b1; op_sz_h = 1'b1; end
      OP_LW:  op_ld = 1'b1;
      OP_LL:  op_ld = 1'b1;
      OP_SB:  begin op_st = 1'b1; op_sz_b = 1'b1; end
      OP_SH:  begin op_st = 1'b1; op_sz_h = 1'b1; end
      OP_SW:  op_st = 1'b1;
      OP_SC:  begin op_st = 1'b1; op_sc = 1'b1; end
      default: ;
    endcase
  end

  // word size is implied for any memory op that is neither byte nor halfword
  assign misal = (op_sz_h && mem_addr_i[0]) ||
                 ((op_ld || op_st) && !op_sz_b && !op_sz_h && (mem_addr_i[1:0] != 2'b00));

`ifdef MEM_LSU_LLSC_EN
  logic llbit_q;
  assign sc_fail = op_sc && !llbit_q;
`else
  assign sc_fail = 1'b0;
`endif

  assign go = (op_ld || op_st) && !misal && !sc_fail;

  always_comb begin
    if (op_sz_b) begin
      sel_c   = 4'b1000 >> mem_addr_i[1:0];
      wdata_c = {4{mem_sdata_i[7:0]}};
    end else if (op_sz_h) begin
      sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      wdata_c = {2{mem_sdata_i[15:0]}};
    end else begin
      sel_c   = 4'b1111;
      wdata_c = mem_sdata_i;
    end
  end

  // big-endian lanes: byte offset 0 is the most significant byte
  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    ld_b = ldata_q[31:24];
      2'd1:    ld_b = ldata_q[23:16];
      2'd2:    ld_b = ldata_q[15:8];
      default: ld_b = ldata_q[7:0];
    endcase
    ld_h = mem_addr_i[1] ? ldata_q[15:0] : ldata_q[31:16];
    if (op_sz_b) begin
      ld_ext = op_sx ? {{24{ld_b[7]}}, ld_b} : {24'd0, ld_b};
    end else if (op_sz_h) begin
      ld_ext = op_sx ? {{16{ld_h[15]}}, ld_h} : {16'd0, ld_h};
    end else begin
      ld_ext = ldata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= 4'd0;
      wdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
      ldata_q   <= 32'd0;
      cnt_q     <= '0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            req_q   <= 1'b1;
            we_q    <= op_st;
            addr_q  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            sel_q   <= sel_c;
            wdata_q <= wdata_c;
            cnt_q   <= CNT_W'(TIMEOUT);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dm.dm_ack_i) begin
            req_q   <= 1'b0;
            ldata_q <= dm.dm_rdata_i;
            state_q <= S_DONE;
          end else if ((TIMEOUT != 0) && (cnt_q == '0)) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_LSU_LLSC_EN
  // an LL completing in the same cycle as a clear request keeps the link
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_q <= 1'b0;
    end else if ((state_q == S_DONE) && (mem_op_i == OP_LL) && !bus_err_q) begin
      llbit_q <= 1'b1;
    end else if (llbit_clr_i || ((state_q == S_DONE) && op_sc)) begin
      llbit_q <= 1'b0;
    end
  end
`endif

  assign dm.dm_req_o   = req_q;
  assign dm.dm_we_o    = we_q;
  assign dm.dm_addr_o  = addr_q;
  assign dm.dm_sel_o   = sel_q;
  assign dm.dm_wdata_o = wdata_q;
  assign bus_err_o     = bus_err_q;

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    whilo_o    = whilo_i;
    stallreq_o = 1'b0;
    excp_o     = 2'b00;
    if (rst) begin
      wd_o    = 5'd0;
      wreg_o  = 1'b0;
      wdata_o = 32'd0;
      hi_o    = 32'd0;
      lo_o    = 32'd0;
      whilo_o = 1'b0;
    end else begin
      case (state_q)
        S_BUSY: begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
        end
        S_DONE: begin
          if (bus_err_q) begin
            wreg_o = 1'b0;
          end else if (op_ld) begin
            wdata_o = ld_ext;
          end else if (op_sc) begin
            wdata_o = 32'd1;
          end
        end
        default: begin
          if (misal) begin
            excp_o = {op_st, op_ld};
            wreg_o = 1'b0;
          end else if (sc_fail) begin
            wdata_o = 32'd0;
          end else if (go) begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with TIMEOUT = 4.
module tb_mem_lsu;
  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        whilo_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        stallreq_o;
  logic [1:0]  excp_o;
  logic        bus_err_o;
`ifdef MEM_LSU_LLSC_EN
  logic        llbit_clr_i;
  logic        clr_done_g;
`endif

  int checks = 0;
  int errors = 0;

  mem_lsu_if #(.ADDR_W(32)) dm_bus ();

  mem_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .whilo_i     (whilo_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .whilo_o     (whilo_o),
    .stallreq_o  (stallreq_o),
    .excp_o      (excp_o),
    .bus_err_o   (bus_err_o),
`ifdef MEM_LSU_LLSC_EN
    .llbit_clr_i (llbit_clr_i),
`endif
    .dm          (dm_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete aligned access with ack in cycle k; checks latency, bus fields and DONE result.
  task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] sdata, input logic [31:0] rdata, input int k,
                     input logic [3:0] e_sel, input logic [31:0] e_bus_wd,
                     input logic [31:0] e_wdata);
    logic is_st;
    logic [31:0] e_addr;
    is_st  = (op == 4'd6) || (op == 4'd7) || (op == 4'd8) || (op == 4'd10);
    e_addr = addr & 32'hFFFF_FFFC;
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_sdata_i = sdata;
    wreg_i      = 1'b1;
    wdata_i     = 32'h0BAD_0BAD;
    #1;
    chk({tag, " stall c0"}, 32'(stallreq_o), 32'd1);
    chk({tag, " req c0"}, 32'(dm_bus.dm_req_o), 32'd0);
    for (int c = 1; c <= k; c++) begin
      tick();
      if (c == k) begin
        dm_bus.dm_ack_i   = 1'b1;
        dm_bus.dm_rdata_i = rdata;
      end
      #1;
      chk({tag, " stall busy"}, 32'(stallreq_o), 32'd1);
      chk({tag, " req busy"}, 32'(dm_bus.dm_req_o), 32'd1);
      if (c == 1) begin
        chk({tag, " sel"}, 32'(dm_bus.dm_sel_o), 32'(e_sel));
        chk({tag, " we"}, 32'(dm_bus.dm_we_o), 32'(is_st));
        chk({tag, " addr"}, dm_bus.dm_addr_o, e_addr);
        if (is_st) chk({tag, " bus wdata"}, dm_bus.dm_wdata_o, e_bus_wd);
      end
    end
    tick();
`ifdef MEM_LSU_LLSC_EN
    llbit_clr_i = clr_done_g;
`endif
    dm_bus.dm_ack_i   = 1'b0;
    dm_bus.dm_rdata_i = 32'd0;
    #1;
    chk({tag, " stall done"}, 32'(stallreq_o), 32'd0);
    chk({tag, " req done"}, 32'(dm_bus.dm_req_o), 32'd0);
    chk({tag, " bus_err done"}, 32'(bus_err_o), 32'd0);
    chk({tag, " wdata_o"}, wdata_o, e_wdata);
    chk({tag, " wreg_o"}, 32'(wreg_o), 32'd1);
    tick();
`ifdef MEM_LSU_LLSC_EN
    llbit_clr_i = 1'b0;
`endif
    mem_op_i = 4'd0;
    #1;
    chk({tag, " stall idle"}, 32'(stallreq_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    wd_i = 5'h1F;
    wreg_i = 1'b1;
    wdata_i = 32'h1234_5678;
    hi_i = 32'hAAAA_0001;
    lo_i = 32'h5555_0002;
    whilo_i = 1'b1;
    mem_op_i = 4'd5;
    mem_addr_i = 32'h102;
    mem_sdata_i = 32'd0;
    dm_bus.dm_ack_i = 1'b0;
    dm_bus.dm_rdata_i = 32'd0;
`ifdef MEM_LSU_LLSC_EN
    llbit_clr_i = 1'b0;
    clr_done_g = 1'b0;
`endif

    // reset: registered bus fields zero, combinational outputs forced to zero
    tick();
    tick();
    #1;
    chk("rst wd_o", 32'(wd_o), 32'd0);
    chk("rst wreg_o", 32'(wreg_o), 32'd0);
    chk("rst wdata_o", wdata_o, 32'd0);
    chk("rst hi_o", hi_o, 32'd0);
    chk("rst whilo_o", 32'(whilo_o), 32'd0);
    chk("rst excp_o", 32'(excp_o), 32'd0);
    chk("rst stall", 32'(stallreq_o), 32'd0);
    chk("rst req", 32'(dm_bus.dm_req_o), 32'd0);
    chk("rst we", 32'(dm_bus.dm_we_o), 32'd0);
    chk("rst addr", dm_bus.dm_addr_o, 32'd0);
    chk("rst sel", 32'(dm_bus.dm_sel_o), 32'd0);
    chk("rst bus wdata", dm_bus.dm_wdata_o, 32'd0);
    chk("rst bus_err", 32'(bus_err_o), 32'd0);

    // non-memory pass-through
    rst = 1'b0;
    mem_op_i = 4'd0;
    wd_i = 5'd7;
    #1;
    chk("pass wdata_o", wdata_o, 32'h1234_5678);
    chk("pass wreg_o", 32'(wreg_o), 32'd1);
    chk("pass wd_o", 32'(wd_o), 32'd7);
    chk("pass hi_o", hi_o, 32'hAAAA_0001);
    chk("pass lo_o", lo_o, 32'h5555_0002);
    chk("pass whilo_o", 32'(whilo_o), 32'd1);
    chk("pass stall", 32'(stallreq_o), 32'd0);
    mem_op_i = 4'd12;
    #1;
    chk("op12 stall", 32'(stallreq_o), 32'd0);
    chk("op12 wdata_o", wdata_o, 32'h1234_5678);
    mem_op_i = 4'd0;
    tick();

    // loads: lane selection and extension
    txn("lb103",  4'd1, 32'h103, 32'd0, 32'h1122_33F4, 1, 4'b0001, 32'd0, 32'hFFFF_FFF4);
    txn("lbu101", 4'd2, 32'h101, 32'd0, 32'h11A2_3344, 2, 4'b0100, 32'd0, 32'h0000_00A2);
    txn("lb100",  4'd1, 32'h100, 32'd0, 32'h7F00_0000, 1, 4'b1000, 32'd0, 32'h0000_007F);
    txn("lh102",  4'd3, 32'h102, 32'd0, 32'h1234_8765, 1, 4'b0011, 32'd0, 32'hFFFF_8765);
    txn("lhu100", 4'd4, 32'h100, 32'd0, 32'h8765_1234, 3, 4'b1100, 32'd0, 32'h0000_8765);
    txn("lw104",  4'd5, 32'h104, 32'd0, 32'hCAFE_F00D, 1, 4'b1111, 32'd0, 32'hCAFE_F00D);

    // stores: lane selects and replicated data
    txn("sh102", 4'd7, 32'h102, 32'h0000_ABCD, 32'd0, 1, 4'b0011, 32'hABCD_ABCD, 32'h0BAD_0BAD);
    txn("sb101", 4'd6, 32'h101, 32'h1234_5678, 32'd0, 2, 4'b0100, 32'h7878_7878, 32'h0BAD_0BAD);
    txn("sw108", 4'd8, 32'h108, 32'hA5A5_5A5A, 32'd0, 1, 4'b1111, 32'hA5A5_5A5A, 32'h0BAD_0BAD);

    // misaligned accesses: exception, no write-back, no stall, no bus request
    mem_op_i = 4'd5;
    mem_addr_i = 32'h102;
    #1;
    chk("lw102 excp", 32'(excp_o), 32'd1);
    chk("lw102 wreg_o", 32'(wreg_o), 32'd0);
    chk("lw102 stall", 32'(stallreq_o), 32'd0);
    tick();
    chk("lw102 req", 32'(dm_bus.dm_req_o), 32'd0);
    mem_op_i = 4'd7;
    mem_addr_i = 32'h101;
    #1;
    chk("sh101 excp", 32'(excp_o), 32'd2);
    chk("sh101 stall", 32'(stallreq_o), 32'd0);
    mem_op_i = 4'd3;
    mem_addr_i = 32'h103;
    #1;
    chk("lh103 excp", 32'(excp_o), 32'd1);
    tick();
    chk("lh103 req", 32'(dm_bus.dm_req_o), 32'd0);
    mem_op_i = 4'd0;
    #1;
    chk("aligned idle excp", 32'(excp_o), 32'd0);

    // timeout: req rises cycle 1, abort decided cycle 5, bus_err in DONE cycle 6
    mem_op_i = 4'd5;
    mem_addr_i = 32'h200;
    wreg_i = 1'b1;
    #1;
    chk("to stall c0", 32'(stallreq_o), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("to req busy", 32'(dm_bus.dm_req_o), 32'd1);
      chk("to bus_err busy", 32'(bus_err_o), 32'd0);
      chk("to stall busy", 32'(stallreq_o), 32'd1);
    end
    tick();
    chk("to bus_err done", 32'(bus_err_o), 32'd1);
    chk("to req done", 32'(dm_bus.dm_req_o), 32'd0);
    chk("to wreg_o done", 32'(wreg_o), 32'd0);
    chk("to stall done", 32'(stallreq_o), 32'd0);
    tick();
    mem_op_i = 4'd0;
    #1;
    chk("to bus_err after", 32'(bus_err_o), 32'd0);
    chk("to req after", 32'(dm_bus.dm_req_o), 32'd0);

    // ack in the same cycle the timeout would fire: ack wins
    txn("lw204 ack@to", 4'd5, 32'h204, 32'd0, 32'h5555_AAAA, 5, 4'b1111, 32'd0, 32'h5555_AAAA);

    // reset during BUSY, late ack ignored
    mem_op_i = 4'd5;
    mem_addr_i = 32'h300;
    tick();
    chk("rstb req busy", 32'(dm_bus.dm_req_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstb stall in rst", 32'(stallreq_o), 32'd0);
    chk("rstb wdata_o in rst", wdata_o, 32'd0);
    tick();
    rst = 1'b0;
    mem_op_i = 4'd0;
    wdata_i = 32'h1357_9BDF;
    dm_bus.dm_ack_i = 1'b1;
    dm_bus.dm_rdata_i = 32'h7777_7777;
    #1;
    chk("rstb req after", 32'(dm_bus.dm_req_o), 32'd0);
    chk("rstb stall after", 32'(stallreq_o), 32'd0);
    chk("rstb wdata_o", wdata_o, 32'h1357_9BDF);
    tick();
    dm_bus.dm_ack_i = 1'b0;
    dm_bus.dm_rdata_i = 32'd0;
    #1;
    chk("rstb late ack req", 32'(dm_bus.dm_req_o), 32'd0);
    chk("rstb late ack bus_err", 32'(bus_err_o), 32'd0);
    txn("lw304 post-rst", 4'd5, 32'h304, 32'd0, 32'h0BEE_F000, 1, 4'b1111, 32'd0, 32'h0BEE_F000);

    // LL then SC: SC stores and writes 1
    txn("ll10c", 4'd9,  32'h10C, 32'd0, 32'h0102_0304, 1, 4'b1111, 32'd0, 32'h0102_0304);
    txn("sc10c", 4'd10, 32'h10C, 32'h0000_0099, 32'd0, 1, 4'b1111, 32'h0000_0099, 32'd1);

`ifdef MEM_LSU_LLSC_EN
    // link consumed by the previous SC: this SC fails
    mem_op_i = 4'd10;
    mem_addr_i = 32'h10C;
    wreg_i = 1'b1;
    wdata_i = 32'h0BAD_0BAD;
    #1;
    chk("sc2 stall", 32'(stallreq_o), 32'd0);
    chk("sc2 wdata_o", wdata_o, 32'd0);
    chk("sc2 wreg_o", 32'(wreg_o), 32'd1);
    tick();
    chk("sc2 req", 32'(dm_bus.dm_req_o), 32'd0);
    mem_op_i = 4'd0;

    // LL, clear, SC: no bus access, writes 0
    #1;
    txn("ll400", 4'd9, 32'h400, 32'd0, 32'h4444_0000, 1, 4'b1111, 32'd0, 32'h4444_0000);
    llbit_clr_i = 1'b1;
    tick();
    llbit_clr_i = 1'b0;
    mem_op_i = 4'd10;
    mem_addr_i = 32'h400;
    wdata_i = 32'h0BAD_0BAD;
    #1;
    chk("scclr stall", 32'(stallreq_o), 32'd0);
    chk("scclr wdata_o", wdata_o, 32'd0);
    tick();
    chk("scclr req", 32'(dm_bus.dm_req_o), 32'd0);
    mem_op_i = 4'd0;
    #1;

    // clear in the LL DONE cycle loses to the LL set
    clr_done_g = 1'b1;
    txn("ll404 clr", 4'd9, 32'h404, 32'd0, 32'h0000_4040, 1, 4'b1111, 32'd0, 32'h0000_4040);
    clr_done_g = 1'b0;
    txn("sc404", 4'd10, 32'h404, 32'h0000_0055, 32'd0, 1, 4'b1111, 32'h0000_0055, 32'd1);
`else
    // without the link bit, SC always performs the store and writes 1
    txn("sc10c again", 4'd10, 32'h10C, 32'h0000_0066, 32'd0, 2, 4'b1111, 32'h0000_0066, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
